// File: rtl/step_pulse_gen_pkg.sv
// Shared types and default widths for the step-pulse generator and the
// motion-command block that drives it.
package step_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  localparam int DEF_CH    = 2;
  localparam int DEF_DIV_W = 21;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_PW    = 4;

endpackage

// File: rtl/step_pulse_gen_chan.sv
// One step-pulse channel: IDLE/RUN FSM, period divider and, when
// STEP_PULSE_GEN_BURST_EN is defined, the burst step counter and done pulse.
module step_chan
  import step_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PW    = DEF_PW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] steps,
  output logic             step_out,
  output logic             busy,
  output logic             done
);

  localparam logic [DIV_W-1:0] P_MIN = DIV_W'(PW + 1);

  state_t           state, state_n;
  logic [DIV_W-1:0] d, d_n;
  logic [DIV_W-1:0] last, last_n;
  logic [DIV_W-1:0] eff;
  logic             done_r, done_n;
  logic             zero_burst;

`ifdef STEP_PULSE_GEN_BURST_EN
  logic             mode_l, mode_n;
  logic [CNT_W-1:0] steps_l, steps_n;
  logic [CNT_W-1:0] s, s_n;

  // A zero-length burst holds RUN for one silent cycle before reporting done.
  assign zero_burst = (mode_l == MODE_BURST) && (steps_l == '0);
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, steps};
  assign zero_burst = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      d       <= '0;
      last    <= '0;
      done_r  <= 1'b0;
`ifdef STEP_PULSE_GEN_BURST_EN
      mode_l  <= MODE_CONT;
      steps_l <= '0;
      s       <= '0;
`endif
    end else begin
      state   <= state_n;
      d       <= d_n;
      last    <= last_n;
      done_r  <= done_n;
`ifdef STEP_PULSE_GEN_BURST_EN
      mode_l  <= mode_n;
      steps_l <= steps_n;
      s       <= s_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    d_n     = d;
    last_n  = last;
    done_n  = 1'b0;
    eff     = (period < P_MIN) ? P_MIN : period;
`ifdef STEP_PULSE_GEN_BURST_EN
    mode_n  = mode_l;
    steps_n = steps_l;
    s_n     = s;
`endif
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_n = ST_RUN;
          d_n     = '0;
          last_n  = eff - DIV_W'(1);
`ifdef STEP_PULSE_GEN_BURST_EN
          mode_n  = mode;
          steps_n = steps;
          s_n     = '0;
`endif
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_IDLE;
          d_n     = '0;
        end else if (zero_burst) begin
          state_n = ST_IDLE;
          d_n     = '0;
          done_n  = 1'b1;
        end else if (d == last) begin
          d_n = '0;
`ifdef STEP_PULSE_GEN_BURST_EN
          if (mode_l == MODE_BURST) begin
            if (s == steps_l - CNT_W'(1)) begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
              s_n     = '0;
            end else begin
              s_n = s + CNT_W'(1);
            end
          end
`endif
        end else begin
          d_n = d + DIV_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy     = (state == ST_RUN);
  assign step_out = busy && (d < DIV_W'(PW)) && !zero_burst;
  assign done     = done_r;

endmodule

// File: rtl/step_pulse_gen.sv
// Multi-channel step-pulse generator: CH independent step_chan instances.
// Burst mode is built only when STEP_PULSE_GEN_BURST_EN is defined.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PW    = DEF_PW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       start,
  input  logic [CH-1:0]       stop,
  input  logic [CH-1:0]       mode,
  input  logic [CH*DIV_W-1:0] period,
  input  logic [CH*CNT_W-1:0] steps,
  output logic [CH-1:0]       step_out,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       done
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    step_chan #(
      .DIV_W(DIV_W),
      .CNT_W(CNT_W),
      .PW   (PW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .start   (start[i]),
      .stop    (stop[i]),
      .mode    (mode[i]),
      .period  (period[i*DIV_W +: DIV_W]),
      .steps   (steps[i*CNT_W +: CNT_W]),
      .step_out(step_out[i]),
      .busy    (busy[i]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen (CH=2, DIV_W=21, CNT_W=16, PW=4);
// burst expectations follow STEP_PULSE_GEN_BURST_EN.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start, stop, mode;
  logic [41:0] period;
  logic [31:0] steps;
  logic [1:0]  step_out, busy, done;

  int vectors = 0;
  int errors  = 0;

  step_pulse_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .period(period), .steps(steps), .step_out(step_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; on return the bench sits in the first RUN cycle (k=0).
  task automatic launch(input int ch, input int per, input logic md, input int stp);
    period[ch*21 +: 21] = 21'(per);
    steps[ch*16 +: 16]  = 16'(stp);
    mode[ch]            = md;
    start[ch]           = 1'b1;
    tick();
    start[ch]           = 1'b0;
  endtask

  task automatic halt(input int ch);
    stop[ch] = 1'b1;
    tick();
    stop[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = '0; stop = '0; mode = '0; period = '0; steps = '0;
    #3;
    vectors++;
    if ({step_out, busy, done} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b required 000000", {step_out, busy, done});
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    vectors++;
    if ({step_out, busy, done} !== 6'b0) begin
      errors++; $display("FAIL reset_release got %b required 000000", {step_out, busy, done});
    end
  endtask

  task automatic test_continuous();
    launch(0, 10, 1'b0, 0);
    for (int k = 0; k < 35; k++) begin
      vectors++;
      if (step_out[0] !== ((k % 10) < 4) || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
        errors++; $display("FAIL cont k=%0d got step=%b busy=%b done=%b required step=%b busy=1 done=0",
                           k, step_out[0], busy[0], done[0], (k % 10) < 4);
      end
      tick();
    end
    halt(0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({step_out[0], busy[0], done[0]} !== 3'b000) begin
        errors++; $display("FAIL cont_stop k=%0d got %b required 000", k, {step_out[0], busy[0], done[0]});
      end
      tick();
    end
  endtask

  task automatic test_start_stop_same();
    start[0] = 1'b1; stop[0] = 1'b1; period[20:0] = 21'd10;
    tick();
    start[0] = 1'b0; stop[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({step_out[0], busy[0]} !== 2'b00) begin
        errors++; $display("FAIL start_stop k=%0d got %b required 00", k, {step_out[0], busy[0]});
      end
      tick();
    end
  endtask

  task automatic test_start_in_run();
    launch(0, 10, 1'b0, 0);
    for (int k = 0; k < 30; k++) begin
      if (k == 3) begin
        period[20:0] = 21'd20;
        start[0]     = 1'b1;
      end else begin
        start[0] = 1'b0;
      end
      vectors++;
      if (step_out[0] !== ((k % 10) < 4) || busy[0] !== 1'b1) begin
        errors++; $display("FAIL restart k=%0d got step=%b busy=%b required step=%b busy=1",
                           k, step_out[0], busy[0], (k % 10) < 4);
      end
      tick();
    end
    start[0] = 1'b0;
    halt(0);
  endtask

  task automatic test_clamp();
    launch(0, 0, 1'b0, 0);
    for (int k = 0; k < 15; k++) begin
      vectors++;
      if (step_out[0] !== ((k % 5) < 4) || busy[0] !== 1'b1) begin
        errors++; $display("FAIL clamp0 k=%0d got step=%b busy=%b required step=%b busy=1",
                           k, step_out[0], busy[0], (k % 5) < 4);
      end
      tick();
    end
    halt(0);
`ifdef STEP_PULSE_GEN_BURST_EN
    launch(0, 2, 1'b1, 2);
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (step_out[0] !== (k < 10 && (k % 5) < 4) || busy[0] !== (k < 10) || done[0] !== (k == 10)) begin
        errors++; $display("FAIL clamp_burst k=%0d got step=%b busy=%b done=%b required step=%b busy=%b done=%b",
                           k, step_out[0], busy[0], done[0], k < 10 && (k % 5) < 4, k < 10, k == 10);
      end
      tick();
    end
`endif
  endtask

  task automatic test_burst();
    launch(0, 8, 1'b1, 3);
`ifdef STEP_PULSE_GEN_BURST_EN
    for (int k = 0; k < 27; k++) begin
      vectors++;
      if (step_out[0] !== (k < 24 && (k % 8) < 4) || busy[0] !== (k < 24) || done[0] !== (k == 24)) begin
        errors++; $display("FAIL burst k=%0d got step=%b busy=%b done=%b required step=%b busy=%b done=%b",
                           k, step_out[0], busy[0], done[0], k < 24 && (k % 8) < 4, k < 24, k == 24);
      end
      tick();
    end
    launch(0, 8, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (step_out[0] !== 1'b0 || busy[0] !== (k == 0) || done[0] !== (k == 1)) begin
        errors++; $display("FAIL burst_zero k=%0d got step=%b busy=%b done=%b required step=0 busy=%b done=%b",
                           k, step_out[0], busy[0], done[0], k == 0, k == 1);
      end
      tick();
    end
`else
    for (int k = 0; k < 40; k++) begin
      vectors++;
      if (step_out[0] !== ((k % 8) < 4) || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
        errors++; $display("FAIL burst_off k=%0d got step=%b busy=%b done=%b required step=%b busy=1 done=0",
                           k, step_out[0], busy[0], done[0], (k % 8) < 4);
      end
      tick();
    end
    halt(0);
`endif
  endtask

  task automatic test_back_to_back();
`ifdef STEP_PULSE_GEN_BURST_EN
    launch(0, 5, 1'b1, 1);
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_done got done=%b busy=%b required done=1 busy=0", done[0], busy[0]);
    end
    launch(0, 5, 1'b1, 1);
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (step_out[0] !== (k < 4) || busy[0] !== (k < 5) || done[0] !== (k == 5)) begin
        errors++; $display("FAIL b2b k=%0d got step=%b busy=%b done=%b required step=%b busy=%b done=%b",
                           k, step_out[0], busy[0], done[0], k < 4, k < 5, k == 5);
      end
      tick();
    end
`endif
  endtask

  task automatic test_independence_reset();
    period = {21'd9, 21'd6};
    steps  = {16'd4, 16'd0};
    mode   = 2'b10;
    start  = 2'b11;
    tick();
    start  = 2'b00;
    for (int k = 0; k < 20; k++) begin
      vectors++;
      if (step_out !== {((k % 9) < 4), ((k % 6) < 4)} || busy !== 2'b11 || done !== 2'b00) begin
        errors++; $display("FAIL indep k=%0d got step=%b busy=%b done=%b required step=%b busy=11 done=00",
                           k, step_out, busy, done, {((k % 9) < 4), ((k % 6) < 4)});
      end
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({step_out, busy, done} !== 6'b0) begin
      errors++; $display("FAIL async_reset got %b required 000000", {step_out, busy, done});
    end
    tick(); tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if ({step_out, busy, done} !== 6'b0) begin
        errors++; $display("FAIL post_reset k=%0d got %b required 000000", k, {step_out, busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_start_stop_same();
    test_start_in_run();
    test_clamp();
    test_burst();
    test_back_to_back();
    test_independence_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
